// File: rtl/std_cache_pkg.sv
//------------------------------------------------------------------------------
// Module : std_cache_pkg
// Brief  : Requester-class decode and AXI channel types shared by the cache.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package std_cache_pkg;

  localparam int unsigned c_axi_id_width   = 4;
  localparam int unsigned c_axi_addr_width = 64;
  localparam int unsigned c_axi_data_width = 64;
  localparam int unsigned c_num_classes    = 3;

  typedef enum logic [1:0] {
    CLS_ICACHE  = 2'd0,
    CLS_BYPASS  = 2'd1,
    CLS_DCACHE  = 2'd2,
    CLS_UNKNOWN = 2'd3
  } req_class_e;

  localparam logic [3:0] c_id_icache     = 4'b0000;
  localparam logic [1:0] c_id_bypass_pfx = 2'b10;   // 4'b10xx
  localparam logic [3:0] c_id_dcache     = 4'b1100;

  typedef struct packed {
    logic [c_axi_id_width-1:0]   id;
    logic [c_axi_addr_width-1:0] addr;
    logic [7:0]                  len;
    logic [2:0]                  size;
    logic [1:0]                  burst;
  } std_axi_ax_t;

  typedef struct packed {
    logic [c_axi_data_width-1:0]   data;
    logic [c_axi_data_width/8-1:0] strb;
    logic                          last;
  } std_axi_w_t;

  typedef struct packed {
    logic [c_axi_id_width-1:0] id;
    logic [1:0]                resp;
  } std_axi_b_t;

  typedef struct packed {
    logic [c_axi_id_width-1:0]   id;
    logic [c_axi_data_width-1:0] data;
    logic [1:0]                  resp;
    logic                        last;
  } std_axi_r_t;

  typedef struct packed {
    std_axi_ax_t aw;
    logic        aw_valid;
    std_axi_w_t  w;
    logic        w_valid;
    logic        b_ready;
    std_axi_ax_t ar;
    logic        ar_valid;
    logic        r_ready;
  } std_axi_req_t;

  typedef struct packed {
    logic       aw_ready;
    logic       ar_ready;
    logic       w_ready;
    logic       b_valid;
    std_axi_b_t b;
    logic       r_valid;
    std_axi_r_t r;
  } std_axi_rsp_t;

  function automatic req_class_e decode_id(input logic [3:0] id);
    if (id == c_id_icache)                return CLS_ICACHE;
    else if (id[3:2] == c_id_bypass_pfx)  return CLS_BYPASS;
    else if (id == c_id_dcache)           return CLS_DCACHE;
    else                                  return CLS_UNKNOWN;
  endfunction

  // Unknown IDs map to no counter, so they are never throttled or counted.
  function automatic logic [c_num_classes-1:0] class_onehot(input req_class_e cls);
    case (cls)
      CLS_ICACHE: return 3'b001;
      CLS_BYPASS: return 3'b010;
      CLS_DCACHE: return 3'b100;
      default:    return 3'b000;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/std_cache_txn_counter.sv
//------------------------------------------------------------------------------
// Module : std_cache_txn_counter
// Brief  : Outstanding-transaction counter with limit, zero and underflow flags.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module std_cache_txn_counter #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc,
  input  logic             dec,
  input  logic [WIDTH-1:0] limit,
  output logic             at_limit,
  output logic             zero,
  output logic             underflow
);

  logic [WIDTH-1:0] r_count;
  logic             w_dec_eff;

  assign zero      = (r_count == '0);
  assign at_limit  = (r_count == limit);
  assign underflow = dec & zero;
  // A decrement at zero is dropped, so a simultaneous increment still counts.
  assign w_dec_eff = dec & ~zero;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_count <= '0;
    end else if (inc && !w_dec_eff) begin
      r_count <= r_count + WIDTH'(1);
    end else if (w_dec_eff && !inc) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/std_cache_axi_txn_limiter.sv
//------------------------------------------------------------------------------
// Module : std_cache_axi_txn_limiter
// Brief  : Per-class AXI outstanding-transaction limiter with idle/error flags.
//          Optional watchdog enabled by defining STD_CACHE_AXI_WATCHDOG_EN.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module std_cache_axi_txn_limiter
  import std_cache_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned TimeoutCycles  = 1024,
  parameter int unsigned AxiIdWidth     = 4,
  parameter type         axi_req_t      = std_cache_pkg::std_axi_req_t,
  parameter type         axi_rsp_t      = std_cache_pkg::std_axi_rsp_t
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  axi_req_t slv_req_i,
  output axi_rsp_t slv_resp_o,
  output axi_req_t mst_req_o,
  input  axi_rsp_t mst_resp_i,
  output logic     idle_o,
  output logic     err_o,
  output logic     timeout_o
);

  localparam int unsigned              c_cnt_width = $clog2(MaxOutstanding + 1);
  localparam logic [c_cnt_width-1:0]   c_limit     = c_cnt_width'(MaxOutstanding);

  req_class_e w_ar_cls, w_aw_cls, w_r_cls, w_b_cls;
  logic       w_ar_block, w_aw_block;
  logic       w_ar_hs, w_aw_hs, w_r_last_hs, w_b_hs;
  logic       w_err_set;
  logic       r_err;

  logic [c_num_classes-1:0] w_rd_inc, w_rd_dec, w_wr_inc, w_wr_dec;
  logic [c_num_classes-1:0] w_rd_at_limit, w_wr_at_limit;
  logic [c_num_classes-1:0] w_rd_zero, w_wr_zero;
  logic [c_num_classes-1:0] w_rd_uflow, w_wr_uflow;

  always_comb begin
    w_ar_cls = decode_id(slv_req_i.ar.id[3:0]);
    w_aw_cls = decode_id(slv_req_i.aw.id[3:0]);
    w_r_cls  = decode_id(mst_resp_i.r.id[3:0]);
    w_b_cls  = decode_id(mst_resp_i.b.id[3:0]);

    w_ar_block = |(class_onehot(w_ar_cls) & w_rd_at_limit);
    w_aw_block = |(class_onehot(w_aw_cls) & w_wr_at_limit);

    mst_req_o          = slv_req_i;
    mst_req_o.ar_valid = slv_req_i.ar_valid & ~w_ar_block;
    mst_req_o.aw_valid = slv_req_i.aw_valid & ~w_aw_block;

    slv_resp_o          = mst_resp_i;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready & ~w_ar_block;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready & ~w_aw_block;

    w_ar_hs     = mst_req_o.ar_valid & mst_resp_i.ar_ready;
    w_aw_hs     = mst_req_o.aw_valid & mst_resp_i.aw_ready;
    w_r_last_hs = mst_resp_i.r_valid & slv_req_i.r_ready & mst_resp_i.r.last;
    w_b_hs      = mst_resp_i.b_valid & slv_req_i.b_ready;

    w_rd_inc = w_ar_hs     ? class_onehot(w_ar_cls) : '0;
    w_rd_dec = w_r_last_hs ? class_onehot(w_r_cls)  : '0;
    w_wr_inc = w_aw_hs     ? class_onehot(w_aw_cls) : '0;
    w_wr_dec = w_b_hs      ? class_onehot(w_b_cls)  : '0;

    w_err_set = (w_r_last_hs && (w_r_cls == CLS_UNKNOWN))
              | (w_b_hs && (w_b_cls == CLS_UNKNOWN))
              | (|w_rd_uflow) | (|w_wr_uflow);
  end

  for (genvar c = 0; c < c_num_classes; c++) begin : g_cls
    std_cache_txn_counter #(
      .WIDTH (c_cnt_width)
    ) u_rd_cnt (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .inc       (w_rd_inc[c]),
      .dec       (w_rd_dec[c]),
      .limit     (c_limit),
      .at_limit  (w_rd_at_limit[c]),
      .zero      (w_rd_zero[c]),
      .underflow (w_rd_uflow[c])
    );

    std_cache_txn_counter #(
      .WIDTH (c_cnt_width)
    ) u_wr_cnt (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .inc       (w_wr_inc[c]),
      .dec       (w_wr_dec[c]),
      .limit     (c_limit),
      .at_limit  (w_wr_at_limit[c]),
      .zero      (w_wr_zero[c]),
      .underflow (w_wr_uflow[c])
    );
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end

  // Derived only from counter flops, so it reflects the post-response state.
  assign idle_o = &{w_rd_zero, w_wr_zero};
  assign err_o  = r_err;

`ifdef STD_CACHE_AXI_WATCHDOG_EN
  logic [31:0] r_wdog_cnt;
  logic        r_timeout;
  logic        w_resp_hs;
  logic        w_unused_cfg;

  assign w_resp_hs    = (mst_resp_i.r_valid & slv_req_i.r_ready) | w_b_hs;
  assign w_unused_cfg = ^32'(AxiIdWidth);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_wdog_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      if (idle_o || w_resp_hs) begin
        r_wdog_cnt <= '0;
      end else if (r_wdog_cnt != '1) begin
        r_wdog_cnt <= r_wdog_cnt + 32'd1;
      end
      if (!idle_o && !w_resp_hs && (r_wdog_cnt == 32'(TimeoutCycles - 1))) begin
        r_timeout <= 1'b1;
      end
    end
  end

  assign timeout_o = r_timeout;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{32'(TimeoutCycles), 32'(AxiIdWidth)};
  assign timeout_o    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_std_cache_axi_txn_limiter.sv
//------------------------------------------------------------------------------
// Module : tb_std_cache_axi_txn_limiter
// Brief  : Scoreboard bench for the per-class AXI transaction limiter.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_std_cache_axi_txn_limiter;
  import std_cache_pkg::*;

  localparam int unsigned c_max_out = 4;
  localparam int unsigned c_timeout = 16;
  localparam logic [3:0]  c_id_i    = 4'b0000;
  localparam logic [3:0]  c_id_byp  = 4'b1001;
  localparam logic [3:0]  c_id_d    = 4'b1100;
  localparam logic [3:0]  c_id_unk  = 4'b0101;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  std_axi_req_t slv_req;
  std_axi_rsp_t slv_resp;
  std_axi_req_t mst_req;
  std_axi_rsp_t mst_resp;
  logic         idle_o, err_o, timeout_o;

  int errors = 0;
  int checks = 0;

  logic [63:0] exp_ar_q[$];
  logic [63:0] exp_aw_q[$];
  logic [63:0] exp_r_q[$];
  logic [63:0] exp_b_q[$];

  always #5 clk_i = ~clk_i;

  std_cache_axi_txn_limiter #(
    .MaxOutstanding (c_max_out),
    .TimeoutCycles  (c_timeout),
    .AxiIdWidth     (4),
    .axi_req_t      (std_axi_req_t),
    .axi_rsp_t      (std_axi_rsp_t)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .slv_req_i  (slv_req),
    .slv_resp_o (slv_resp),
    .mst_req_o  (mst_req),
    .mst_resp_i (mst_resp),
    .idle_o     (idle_o),
    .err_o      (err_o),
    .timeout_o  (timeout_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Handshakes are stable between the driving edge and the next edge.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (mst_req.ar_valid && mst_resp.ar_ready) begin
        check_eq("ar_sb_pending", 64'(exp_ar_q.size() != 0), 64'd1);
        if (exp_ar_q.size() != 0) check_eq("ar_addr", mst_req.ar.addr, exp_ar_q.pop_front());
      end
      if (mst_req.aw_valid && mst_resp.aw_ready) begin
        check_eq("aw_sb_pending", 64'(exp_aw_q.size() != 0), 64'd1);
        if (exp_aw_q.size() != 0) check_eq("aw_addr", mst_req.aw.addr, exp_aw_q.pop_front());
      end
      if (slv_resp.r_valid && slv_req.r_ready) begin
        check_eq("r_sb_pending", 64'(exp_r_q.size() != 0), 64'd1);
        if (exp_r_q.size() != 0) check_eq("r_data", slv_resp.r.data, exp_r_q.pop_front());
      end
      if (slv_resp.b_valid && slv_req.b_ready) begin
        check_eq("b_sb_pending", 64'(exp_b_q.size() != 0), 64'd1);
        if (exp_b_q.size() != 0) check_eq("b_id", 64'(slv_resp.b.id), exp_b_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic bus_idle();
    slv_req           = '0;
    slv_req.r_ready   = 1'b1;
    slv_req.b_ready   = 1'b1;
    mst_resp          = '0;
    mst_resp.ar_ready = 1'b1;
    mst_resp.aw_ready = 1'b1;
    mst_resp.w_ready  = 1'b1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    bus_idle();
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic send_ar(input logic [3:0] id, input logic [63:0] addr);
    slv_req.ar_valid = 1'b1;
    slv_req.ar.id    = id;
    slv_req.ar.addr  = addr;
    exp_ar_q.push_back(addr);
    tick();
    slv_req.ar_valid = 1'b0;
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [63:0] addr);
    slv_req.aw_valid = 1'b1;
    slv_req.aw.id    = id;
    slv_req.aw.addr  = addr;
    exp_aw_q.push_back(addr);
    tick();
    slv_req.aw_valid = 1'b0;
  endtask

  task automatic send_r(input logic [3:0] id, input logic [63:0] data);
    mst_resp.r_valid = 1'b1;
    mst_resp.r.id    = id;
    mst_resp.r.data  = data;
    mst_resp.r.last  = 1'b1;
    exp_r_q.push_back(data);
    tick();
    mst_resp.r_valid = 1'b0;
  endtask

  task automatic send_b(input logic [3:0] id);
    mst_resp.b_valid = 1'b1;
    mst_resp.b.id    = id;
    exp_b_q.push_back(64'(id));
    tick();
    mst_resp.b_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL sim_time_limit: got=expired expected=finish");
    $fatal(1, "time limit");
  end

  initial begin
    rst_ni = 1'b0;
    do_reset();

    @(negedge clk_i);
    check_eq("rst_idle", 64'(idle_o), 64'd1);
    check_eq("rst_err", 64'(err_o), 64'd0);
    check_eq("rst_timeout", 64'(timeout_o), 64'd0);

    // Pass-through with readies low, so nothing is counted.
    tick();
    mst_resp.ar_ready = 1'b0;
    slv_req.r_ready   = 1'b0;
    slv_req.b_ready   = 1'b0;
    slv_req.ar_valid  = 1'b1;
    slv_req.ar.id     = c_id_i;
    slv_req.w_valid   = 1'b1;
    slv_req.w.data    = 64'hCAFE_0123_4567_89AB;
    mst_resp.r_valid  = 1'b1;
    mst_resp.b_valid  = 1'b1;
    #1;
    check_eq("pt_ar_valid", 64'(mst_req.ar_valid), 64'd1);
    check_eq("pt_ar_ready", 64'(slv_resp.ar_ready), 64'd0);
    check_eq("pt_w_valid", 64'(mst_req.w_valid), 64'd1);
    check_eq("pt_w_data", mst_req.w.data, 64'hCAFE_0123_4567_89AB);
    check_eq("pt_r_valid", 64'(slv_resp.r_valid), 64'd1);
    check_eq("pt_b_valid", 64'(slv_resp.b_valid), 64'd1);
    check_eq("pt_r_ready", 64'(mst_req.r_ready), 64'd0);
    tick();
    bus_idle();

    // D$ read limit.
    for (int i = 0; i < 4; i++) send_ar(c_id_d, 64'h1000 + 64'(i));
    slv_req.ar_valid = 1'b1;
    slv_req.ar.id    = c_id_d;
    slv_req.ar.addr  = 64'h1004;
    exp_ar_q.push_back(64'h1004);
    @(negedge clk_i);
    check_eq("d_lim_slv_ready", 64'(slv_resp.ar_ready), 64'd0);
    check_eq("d_lim_mst_valid", 64'(mst_req.ar_valid), 64'd0);
    check_eq("d_lim_idle", 64'(idle_o), 64'd0);
    tick();
    @(negedge clk_i);
    check_eq("d_lim_hold", 64'(mst_req.ar_valid), 64'd0);
    tick();
    mst_resp.r_valid = 1'b1;
    mst_resp.r.id    = c_id_d;
    mst_resp.r.data  = 64'hD0;
    mst_resp.r.last  = 1'b1;
    exp_r_q.push_back(64'hD0);
    @(negedge clk_i);
    check_eq("d_lim_same_cycle", 64'(mst_req.ar_valid), 64'd0);
    tick();
    mst_resp.r_valid = 1'b0;
    @(negedge clk_i);
    check_eq("d_free_mst_valid", 64'(mst_req.ar_valid), 64'd1);
    check_eq("d_free_slv_ready", 64'(slv_resp.ar_ready), 64'd1);
    tick();
    slv_req.ar_valid = 1'b0;
    for (int i = 0; i < 4; i++) send_r(c_id_d, 64'hD1 + 64'(i));
    @(negedge clk_i);
    check_eq("d_drain_idle", 64'(idle_o), 64'd1);
    tick();

    // Bypass write limit does not throttle an I$ read.
    for (int i = 0; i < 4; i++) send_aw(c_id_byp, 64'h2000 + 64'(i));
    slv_req.aw_valid = 1'b1;
    slv_req.aw.id    = c_id_byp;
    slv_req.aw.addr  = 64'h2004;
    slv_req.ar_valid = 1'b1;
    slv_req.ar.id    = c_id_i;
    slv_req.ar.addr  = 64'h3000;
    exp_ar_q.push_back(64'h3000);
    @(negedge clk_i);
    check_eq("byp_aw_blocked", 64'(mst_req.aw_valid), 64'd0);
    check_eq("byp_aw_ready", 64'(slv_resp.aw_ready), 64'd0);
    check_eq("ic_ar_granted", 64'(slv_resp.ar_ready), 64'd1);
    tick();
    slv_req.aw_valid = 1'b0;
    slv_req.ar_valid = 1'b0;
    for (int i = 0; i < 4; i++) send_b(c_id_byp);
    send_r(c_id_i, 64'h1C);
    @(negedge clk_i);
    check_eq("byp_drain_idle", 64'(idle_o), 64'd1);
    tick();

    // Same-cycle AW and B for D$ at count 2.
    send_aw(c_id_d, 64'h4000);
    send_aw(c_id_d, 64'h4001);
    slv_req.aw_valid = 1'b1;
    slv_req.aw.id    = c_id_d;
    slv_req.aw.addr  = 64'h4002;
    exp_aw_q.push_back(64'h4002);
    mst_resp.b_valid = 1'b1;
    mst_resp.b.id    = c_id_d;
    exp_b_q.push_back(64'(c_id_d));
    tick();
    slv_req.aw_valid = 1'b0;
    mst_resp.b_valid = 1'b0;
    @(negedge clk_i);
    check_eq("d_same_idle", 64'(idle_o), 64'd0);
    tick();
    send_b(c_id_d);
    @(negedge clk_i);
    check_eq("d_cnt1_idle", 64'(idle_o), 64'd0);
    tick();
    send_b(c_id_d);
    @(negedge clk_i);
    check_eq("d_cnt0_idle", 64'(idle_o), 64'd1);
    check_eq("no_err_yet", 64'(err_o), 64'd0);
    tick();

    // Unknown-ID B.
    send_b(c_id_unk);
    @(negedge clk_i);
    check_eq("unk_b_err", 64'(err_o), 64'd1);
    tick();
    tick();
    tick();
    @(negedge clk_i);
    check_eq("unk_b_sticky", 64'(err_o), 64'd1);
    check_eq("unk_b_idle", 64'(idle_o), 64'd1);
    tick();
    do_reset();
    @(negedge clk_i);
    check_eq("err_cleared", 64'(err_o), 64'd0);
    tick();

    // R-last for I$ at count zero.
    send_r(c_id_i, 64'hEE);
    @(negedge clk_i);
    check_eq("uflow_err", 64'(err_o), 64'd1);
    check_eq("uflow_cnt_zero", 64'(idle_o), 64'd1);
    tick();

    // Watchdog.
    do_reset();
    send_ar(c_id_i, 64'h5000);
    repeat (c_timeout - 1) tick();
    @(negedge clk_i);
    check_eq("wdog_before", 64'(timeout_o), 64'd0);
    tick();
    @(negedge clk_i);
`ifdef STD_CACHE_AXI_WATCHDOG_EN
    check_eq("wdog_fire", 64'(timeout_o), 64'd1);
`else
    check_eq("wdog_off", 64'(timeout_o), 64'd0);
`endif
    tick();
    send_r(c_id_i, 64'h55);
    @(negedge clk_i);
    check_eq("final_idle", 64'(idle_o), 64'd1);
`ifdef STD_CACHE_AXI_WATCHDOG_EN
    check_eq("wdog_sticky", 64'(timeout_o), 64'd1);
`else
    check_eq("wdog_off_end", 64'(timeout_o), 64'd0);
`endif
    check_eq("ar_q_empty", 64'(exp_ar_q.size()), 64'd0);
    check_eq("aw_q_empty", 64'(exp_aw_q.size()), 64'd0);
    check_eq("r_q_empty", 64'(exp_r_q.size()), 64'd0);
    check_eq("b_q_empty", 64'(exp_b_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
